// File: rtl/clock_buffer.sv
// clock_buffer: buffered copy of mclk plus a synchronous monitor
// (edge counter, periodic tick, divided square wave)
module clock_buffer #(
    parameter int CNT_W = 16,
    parameter int DIV   = 4
) (
    input  logic             mclk,
    output logic             bclk,
    input  logic             rst,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             tick,
    output logic             div_clk
);
    localparam int PW = $clog2(DIV);
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic             tick_q, tick_d;
    logic             div_q, div_d;
    // bclk is a pure wire copy so downstream edges line up exactly with mclk
    assign bclk = mclk;
    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        tick_d = pre_q == LAST;
        pre_d  = tick_d ? '0 : pre_q + 1'b1;
        div_d  = div_q ^ tick_d;
    end
    always_ff @(posedge mclk) begin
        if (rst) begin
            cnt_q  <= '0;
            pre_q  <= '0;
            tick_q <= 1'b0;
            div_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pre_q  <= pre_d;
            tick_q <= tick_d;
            div_q  <= div_d;
        end
    end
    assign cycle_cnt = cnt_q;
    assign tick      = tick_q;
    assign div_clk   = div_q;
endmodule

// File: tb/tb_clock_buffer.sv
// tb_clock_buffer: directed checks of clock passthrough, counter, tick, div_clk and wrap
module tb_clock_buffer;
    logic        mclk = 1'b0;
    logic        rst  = 1'b1;
    logic        bclk, tick, div_clk;
    logic [15:0] cycle_cnt;
    logic        bclk_w, tick_w, div_w;
    logic [3:0]  cnt_w;
    logic        bclk_bare, tick_bare, div_bare;
    logic [15:0] cnt_bare;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 mclk = ~mclk;

    clock_buffer u_dut (
        .mclk(mclk), .bclk(bclk), .rst(rst),
        .cycle_cnt(cycle_cnt), .tick(tick), .div_clk(div_clk)
    );

    clock_buffer #(.CNT_W(4)) u_w (
        .mclk(mclk), .bclk(bclk_w), .rst(rst),
        .cycle_cnt(cnt_w), .tick(tick_w), .div_clk(div_w)
    );

    clock_buffer u_bare (
        .mclk(mclk), .bclk(bclk_bare), .rst(),
        .cycle_cnt(cnt_bare), .tick(tick_bare), .div_clk(div_bare)
    );

    task automatic test_phase;
        realtime tm1 = -1, tm2 = -1, tb1 = -1, tb2 = -1;
        fork
            begin
                fork
                    begin @(posedge mclk) tm1 = $realtime; @(posedge mclk) tm2 = $realtime; end
                    begin @(posedge bclk) tb1 = $realtime; @(posedge bclk) tb2 = $realtime; end
                join
            end
            begin #60; end
        join_any
        n_vec++; if (tm1 != tb1) begin n_err++; $display("FAIL phase1: bclk edge %0t mclk edge %0t", tb1, tm1); end
        n_vec++; if (tm2 != tb2) begin n_err++; $display("FAIL phase2: bclk edge %0t mclk edge %0t", tb2, tm2); end
        n_vec++; if (tm2 - tm1 != 10) begin n_err++; $display("FAIL mclk_period: got %0t want 10", tm2 - tm1); end
        n_vec++; if (tb2 - tb1 != 10) begin n_err++; $display("FAIL bclk_period: got %0t want 10", tb2 - tb1); end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) begin
            @(posedge mclk); #2;
            n_vec++; if (bclk !== 1'b1) begin n_err++; $display("FAIL rst_bclk_hi: got %b want 1", bclk); end
            n_vec++; if (cycle_cnt !== 16'd0) begin n_err++; $display("FAIL rst_cnt: got %0d want 0", cycle_cnt); end
            n_vec++; if (tick !== 1'b0) begin n_err++; $display("FAIL rst_tick: got %b want 0", tick); end
            n_vec++; if (div_clk !== 1'b0) begin n_err++; $display("FAIL rst_div: got %b want 0", div_clk); end
            @(negedge mclk); #2;
            n_vec++; if (bclk !== 1'b0) begin n_err++; $display("FAIL rst_bclk_lo: got %b want 0", bclk); end
        end
    endtask

    task automatic test_count_tick;
        @(negedge mclk) rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge mclk);
            n_vec++; if (cycle_cnt !== 16'(k)) begin n_err++; $display("FAIL cnt c%0d: got %0d want %0d", k, cycle_cnt, k); end
            n_vec++; if (tick !== (k % 4 == 0)) begin n_err++; $display("FAIL tick c%0d: got %b want %b", k, tick, k % 4 == 0); end
            n_vec++; if (div_clk !== ((k / 4) % 2 == 1)) begin n_err++; $display("FAIL div c%0d: got %b want %b", k, div_clk, (k / 4) % 2 == 1); end
        end
    endtask

    task automatic test_wrap;
        @(negedge mclk) rst = 1'b1;
        @(negedge mclk) rst = 1'b0;
        n_vec++; if (cnt_w !== 4'd0) begin n_err++; $display("FAIL wrap_rst: got %0d want 0", cnt_w); end
        for (int k = 1; k <= 17; k++) begin
            @(negedge mclk);
            n_vec++; if (cnt_w !== 4'(k % 16)) begin n_err++; $display("FAIL wrap c%0d: got %0d want %0d", k, cnt_w, k % 16); end
        end
    endtask

    task automatic test_mid_reset;
        @(negedge mclk) rst = 1'b1;
        @(negedge mclk) rst = 1'b0;
        repeat (5) @(negedge mclk);
        n_vec++; if (div_clk !== 1'b1) begin n_err++; $display("FAIL mid_pre_div: got %b want 1", div_clk); end
        rst = 1'b1;
        @(posedge mclk); #2;
        n_vec++; if (bclk !== 1'b1) begin n_err++; $display("FAIL mid_bclk: got %b want 1", bclk); end
        @(negedge mclk);
        n_vec++; if (cycle_cnt !== 16'd0) begin n_err++; $display("FAIL mid_cnt: got %0d want 0", cycle_cnt); end
        n_vec++; if (div_clk !== 1'b0) begin n_err++; $display("FAIL mid_div: got %b want 0", div_clk); end
        n_vec++; if (tick !== 1'b0) begin n_err++; $display("FAIL mid_tick: got %b want 0", tick); end
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge mclk);
            n_vec++; if (cycle_cnt !== 16'(k)) begin n_err++; $display("FAIL mid_cnt c%0d: got %0d want %0d", k, cycle_cnt, k); end
            n_vec++; if (tick !== (k == 4)) begin n_err++; $display("FAIL mid_tick c%0d: got %b want %b", k, tick, k == 4); end
            n_vec++; if (div_clk !== (k == 4)) begin n_err++; $display("FAIL mid_div c%0d: got %b want %b", k, div_clk, k == 4); end
        end
    endtask

    task automatic test_bare;
        repeat (3) begin
            @(posedge mclk); #2;
            n_vec++; if (bclk_bare !== 1'b1) begin n_err++; $display("FAIL bare_hi: got %b want 1", bclk_bare); end
            @(negedge mclk); #2;
            n_vec++; if (bclk_bare !== 1'b0) begin n_err++; $display("FAIL bare_lo: got %b want 0", bclk_bare); end
        end
    endtask

    initial begin
        test_phase;
        test_reset;
        test_count_tick;
        test_wrap;
        test_mid_reset;
        test_bare;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/clock_buffer.md
Name: clock_buffer

Overview:
Clock distribution leaf. It drives a buffered copy of the master clock (bclk) with zero phase and frequency offset. It also provides a small synchronous monitor on the same clock: a free-running edge counter, a periodic tick, and a divided square wave. Downstream blocks are clocked from bclk; test logic reads the monitor outputs.

Parameters:
CNT_W, 16, width of the edge counter
DIV, 4, tick period in mclk cycles (legal range 2..65535)

Ports:
mclk  input  1  master clock; all sequential logic is on its rising edge
rst  input  1  reset
bclk  output  1  buffered clock, a combinational copy of mclk
cycle_cnt  output  CNT_W  count of mclk rising edges since reset
tick  output  1  one-cycle pulse every DIV cycles
div_clk  output  1  registered square wave with period 2*DIV mclk cycles
Port declaration order: mclk, bclk, rst, cycle_cnt, tick, div_clk. The first two are positional-compatible with a bare (mclk, bclk) instantiation.

Behaviour:
- Interface: one clock (mclk); reset rst is synchronous and active-high.
- bclk = mclk through a continuous assignment:
  - no flops, no gating, no inserted delay;
  - rising and falling edges occur at the same simulation time as mclk;
  - period equals the mclk period.
- bclk is independent of rst and of all monitor state. It toggles during reset, and also when rst is X/Z or unconnected.
- Reset (rst high at a mclk rising edge): cycle_cnt=0, tick=0, div_clk=0, internal prescaler=0.
- No output is defined before the first reset edge, except bclk.
- cycle_cnt: +1 on every rising edge with rst low. Wraps from 2^CNT_W-1 to 0 with no flag.
- Prescaler: internal counter from 0 to DIV-1.
  - Increments each non-reset cycle.
  - At DIV-1 it returns to 0 on the next edge.
- tick: registered. It is high for exactly one cycle, in the cycle after the prescaler reaches DIV-1.
  - After reset release, the first tick is high in cycle DIV (1-based count of non-reset edges).
  - Ticks then repeat every DIV cycles.
- div_clk: registered. It toggles on every edge where tick is being asserted, so it is high for DIV cycles and low for DIV cycles.
- Reset mid-operation: all monitor state returns to reset values on that edge. A tick pending in the same cycle is dropped. Counting restarts from zero on the first edge with rst low.
- No combinational path from rst to any output.

Test Plan:
- mclk with 10-unit period (toggle every 5). Fork capture of the first two posedges of mclk and of bclk -> t_mclk1 == t_bclk1 and t_mclk2 == t_bclk2 ("phase same"); both periods = 10 ("frequency same").
- Hold rst high for 3 cycles -> bclk keeps toggling identically to mclk; cycle_cnt=0, tick=0, div_clk=0 throughout.
- Release rst, run 12 cycles with DIV=4 -> cycle_cnt 1..12; tick high in cycles 4, 8, 12 only; div_clk goes 0->1 after the cycle-4 tick and 1->0 after the cycle-8 tick.
- CNT_W=4: run 17 cycles after reset -> cycle_cnt reaches 15, then 0, then 1.
- Assert rst for one cycle at cycle 6 (mid-period) -> cycle_cnt=0 and div_clk=0 on that edge; next tick appears 4 cycles after release; bclk is unaffected.
- Leave rst unconnected (two-port instantiation) -> bclk still identical to mclk; simulation compiles and runs.
